// File: rtl/hazard_ctrl_if.sv
// Decode tuple flowing into the hazard unit, and the stall/forwarding controls
// plus stall counter flowing back to the pipeline datapath.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2,
    parameter int CNT_W  = 16
);
    logic [T_W-1:0]    Tuse_rs;
    logic [T_W-1:0]    Tuse_rt;
    logic [T_W-1:0]    TnewD;
    logic [ADDR_W-1:0] A_rsD;
    logic [ADDR_W-1:0] A_rtD;
    logic [ADDR_W-1:0] AwriteD;

    logic              stall;
    logic [1:0]        fwd_rsD;
    logic [1:0]        fwd_rtD;
    logic [1:0]        fwd_rsE;
    logic [1:0]        fwd_rtE;
    logic              fwd_rtM;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
        input  stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM, stall_cnt
    );

    modport slave (
        input  Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
        output stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard tracking for the 5-stage MIPS pipeline: shadows the decode tuple through
// E/M/W and derives stall, bubble and forwarding selects from Tuse/Tnew timing.
module hazard_ctrl #(
    parameter int ADDR_W = 5,
    parameter int T_W    = 2,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    logic [ADDR_W-1:0] a_rs_e;
    logic [ADDR_W-1:0] a_rt_e;
    logic [ADDR_W-1:0] awrite_e;
    logic [T_W-1:0]    tnew_e;
    logic [ADDR_W-1:0] a_rt_m;
    logic [ADDR_W-1:0] awrite_m;
    logic [T_W-1:0]    tnew_m;
    logic [ADDR_W-1:0] awrite_w;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall;

    function automatic logic [T_W-1:0] sat0(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    function automatic logic hz(
        input logic [ADDR_W-1:0] a,
        input logic [T_W-1:0]    t,
        input logic [ADDR_W-1:0] aw_e,
        input logic [T_W-1:0]    t_e,
        input logic [ADDR_W-1:0] aw_m,
        input logic [T_W-1:0]    t_m
    );
        return (a != '0) && (((a == aw_e) && (t_e > t)) || ((a == aw_m) && (t_m > t)));
    endfunction

    // Nearest matching producer wins; a producer not yet ready selects 0 and relies on stall.
    function automatic logic [1:0] fwd_d(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] aw_e,
        input logic [T_W-1:0]    t_e,
        input logic [ADDR_W-1:0] aw_m,
        input logic [T_W-1:0]    t_m,
        input logic [ADDR_W-1:0] aw_w
    );
        if (a == '0)        return 2'd0;
        else if (a == aw_e) return (t_e == '0) ? 2'd1 : 2'd0;
        else if (a == aw_m) return (t_m == '0) ? 2'd2 : 2'd0;
        else if (a == aw_w) return 2'd3;
        else                return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] aw_m,
        input logic [T_W-1:0]    t_m,
        input logic [ADDR_W-1:0] aw_w
    );
        if (a == '0)        return 2'd0;
        else if (a == aw_m) return (t_m == '0) ? 2'd1 : 2'd0;
        else if (a == aw_w) return 2'd2;
        else                return 2'd0;
    endfunction

    assign stall = hz(bus.A_rsD, bus.Tuse_rs, awrite_e, tnew_e, awrite_m, tnew_m)
                 | hz(bus.A_rtD, bus.Tuse_rt, awrite_e, tnew_e, awrite_m, tnew_m);

    assign bus.stall     = stall;
    assign bus.fwd_rsD   = fwd_d(bus.A_rsD, awrite_e, tnew_e, awrite_m, tnew_m, awrite_w);
    assign bus.fwd_rtD   = fwd_d(bus.A_rtD, awrite_e, tnew_e, awrite_m, tnew_m, awrite_w);
    assign bus.fwd_rsE   = fwd_e(a_rs_e, awrite_m, tnew_m, awrite_w);
    assign bus.fwd_rtE   = fwd_e(a_rt_e, awrite_m, tnew_m, awrite_w);
    assign bus.fwd_rtM   = (a_rt_m != '0) && (a_rt_m == awrite_w);
    assign bus.stall_cnt = stall_cnt;

    // A stalled D instruction stays put, so E takes a bubble while M and W keep draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_rs_e    <= '0;
            a_rt_e    <= '0;
            awrite_e  <= '0;
            tnew_e    <= '0;
            a_rt_m    <= '0;
            awrite_m  <= '0;
            tnew_m    <= '0;
            awrite_w  <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                a_rs_e   <= '0;
                a_rt_e   <= '0;
                awrite_e <= '0;
                tnew_e   <= '0;
            end else begin
                a_rs_e   <= bus.A_rsD;
                a_rt_e   <= bus.A_rtD;
                awrite_e <= bus.AwriteD;
                tnew_e   <= sat0(bus.TnewD);
            end
            a_rt_m   <= a_rt_e;
            awrite_m <= awrite_e;
            tnew_m   <= sat0(tnew_e);
            awrite_w <= awrite_m;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random
// decode tuples, compared against a timing model built on absolute ready cycles.
module tb_hazard_ctrl;

    localparam int ADDR_W  = 5;
    localparam int T_W     = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    hazard_ctrl_if #(.ADDR_W(ADDR_W), .T_W(T_W), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.ADDR_W(ADDR_W), .T_W(T_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // In-flight instruction: its addresses and the absolute cycle its result becomes available.
    typedef struct {
        int rs;
        int rt;
        int w;
        int ready;
    } instr_t;

    instr_t pipe [1:3];
    int     now_cyc;
    int     model_cnt;
    bit     model_valid;
    int     checks_total;
    int     checks_passed;
    int     d_tuse_rs, d_tuse_rt, d_tnew, d_rs, d_rt, d_w;
    logic   d_rst;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now_cyc);
    endtask

    function automatic int tnewAt(input int k);
        return (pipe[k].ready > now_cyc) ? pipe[k].ready - now_cyc : 0;
    endfunction

    function automatic bit hazardOn(input int a, input int t);
        if (a == 0) return 1'b0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].w == a && tnewAt(k) > t) return 1'b1;
        return 1'b0;
    endfunction

    // Stage index doubles as the select value: 1 E, 2 M, 3 W.
    function automatic int fwdFromD(input int a);
        if (a == 0) return 0;
        for (int k = 1; k <= 3; k++)
            if (pipe[k].w == a) return (tnewAt(k) == 0) ? k : 0;
        return 0;
    endfunction

    function automatic int fwdFromE(input int a);
        if (a == 0) return 0;
        for (int k = 2; k <= 3; k++)
            if (pipe[k].w == a) return (tnewAt(k) == 0) ? k - 1 : 0;
        return 0;
    endfunction

    function automatic bit expStall();
        return hazardOn(d_rs, d_tuse_rs) || hazardOn(d_rt, d_tuse_rt);
    endfunction

    task automatic applyStimulus(input int tuse_rs, input int tuse_rt, input int tnew,
                                 input int rs, input int rt, input int w, input logic rst);
        d_tuse_rs = tuse_rs; d_tuse_rt = tuse_rt; d_tnew = tnew;
        d_rs = rs; d_rt = rt; d_w = w; d_rst = rst;
        bus.Tuse_rs = T_W'(tuse_rs);
        bus.Tuse_rt = T_W'(tuse_rt);
        bus.TnewD   = T_W'(tnew);
        bus.A_rsD   = ADDR_W'(rs);
        bus.A_rtD   = ADDR_W'(rt);
        bus.AwriteD = ADDR_W'(w);
        reset       = rst;
        #2;
        if (model_valid) begin
            checkOutput("stall",     32'(bus.stall),     32'(expStall()));
            checkOutput("fwd_rsD",   32'(bus.fwd_rsD),   32'(fwdFromD(d_rs)));
            checkOutput("fwd_rtD",   32'(bus.fwd_rtD),   32'(fwdFromD(d_rt)));
            checkOutput("fwd_rsE",   32'(bus.fwd_rsE),   32'(fwdFromE(pipe[1].rs)));
            checkOutput("fwd_rtE",   32'(bus.fwd_rtE),   32'(fwdFromE(pipe[1].rt)));
            checkOutput("fwd_rtM",   32'(bus.fwd_rtM),
                        32'((pipe[2].rt != 0) && (pipe[3].w == pipe[2].rt)));
            checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(model_cnt));
        end
    endtask

    task automatic tick();
        bit st;
        st = expStall();
        @(posedge clk);
        #1;
        if (!d_rst) begin
            for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
            model_cnt   = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (st && model_cnt < CNT_MAX) model_cnt++;
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            if (st) pipe[1] = '{0, 0, 0, 0};
            else    pipe[1] = '{d_rs, d_rt, d_w, now_cyc + d_tnew};
        end
        now_cyc++;
    endtask

    task automatic step(input int tuse_rs, input int tuse_rt, input int tnew,
                        input int rs, input int rt, input int w, input logic rst);
        applyStimulus(tuse_rs, tuse_rt, tnew, rs, rt, w, rst);
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(3, 3, 0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        now_cyc       = 0;
        model_cnt     = 0;
        model_valid   = 1'b0;
        for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};

        // Reset held for two edges with arbitrary decode inputs.
        for (int i = 0; i < 2; i++)
            step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
        applyStimulus(0, 0, 3, 7, 9, 7, 1'b1);
        checkOutput("rst_stall", 32'(bus.stall), 32'd0);
        checkOutput("rst_fwd_rsD", 32'(bus.fwd_rsD), 32'd0);
        checkOutput("rst_fwd_rtE", 32'(bus.fwd_rtE), 32'd0);
        checkOutput("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();
        nops(3);

        // lw $1 followed by a dependent addu: one load-use stall.
        step(1, 3, 3, 0, 0, 1, 1'b1);
        applyStimulus(1, 1, 1, 1, 1, 2, 1'b1);
        checkOutput("lw_use_stall", 32'(bus.stall), 32'd1);
        tick();
        applyStimulus(1, 1, 1, 1, 1, 2, 1'b1);
        checkOutput("lw_use_release", 32'(bus.stall), 32'd0);
        checkOutput("lw_use_fwd_rsD", 32'(bus.fwd_rsD), 32'd0);
        tick();
        applyStimulus(3, 3, 0, 0, 0, 0, 1'b1);
        checkOutput("lw_use_fwd_rsE", 32'(bus.fwd_rsE), 32'd2);
        checkOutput("lw_use_fwd_rtE", 32'(bus.fwd_rtE), 32'd2);
        checkOutput("lw_use_cnt", 32'(bus.stall_cnt), 32'd1);
        tick();
        nops(3);

        // ALU result feeding a branch compare in D.
        step(1, 1, 2, 0, 0, 3, 1'b1);
        applyStimulus(0, 0, 0, 3, 3, 0, 1'b1);
        checkOutput("beq_stall", 32'(bus.stall), 32'd1);
        tick();
        applyStimulus(0, 0, 0, 3, 3, 0, 1'b1);
        checkOutput("beq_release", 32'(bus.stall), 32'd0);
        checkOutput("beq_fwd_rsD", 32'(bus.fwd_rsD), 32'd2);
        checkOutput("beq_fwd_rtD", 32'(bus.fwd_rtD), 32'd2);
        tick();
        nops(3);

        // Register 0 never hazards or forwards.
        step(3, 3, 3, 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3, 0, 0, 0, 0, 1'b1);
            checkOutput("zero_stall", 32'(bus.stall), 32'd0);
            checkOutput("zero_fwd_rsD", 32'(bus.fwd_rsD), 32'd0);
            tick();
        end
        nops(3);

        // ori $5, addu $5, sw $5: store data follows the newest writer.
        step(1, 3, 2, 0, 0, 5, 1'b1);
        step(1, 1, 2, 5, 5, 5, 1'b1);
        applyStimulus(1, 2, 0, 6, 5, 0, 1'b1);
        checkOutput("sw_no_stall", 32'(bus.stall), 32'd0);
        tick();
        applyStimulus(3, 3, 0, 0, 0, 0, 1'b1);
        checkOutput("sw_fwd_rtE", 32'(bus.fwd_rtE), 32'd1);
        tick();
        applyStimulus(3, 3, 0, 0, 0, 0, 1'b1);
        checkOutput("sw_fwd_rtM", 32'(bus.fwd_rtM), 32'd1);
        tick();
        nops(3);

        // Reset asserted during a load-use stall.
        step(1, 3, 3, 0, 0, 1, 1'b1);
        applyStimulus(1, 1, 1, 1, 1, 2, 1'b0);
        checkOutput("midrst_stall_before", 32'(bus.stall), 32'd1);
        tick();
        applyStimulus(1, 1, 1, 1, 1, 2, 1'b1);
        checkOutput("midrst_stall_after", 32'(bus.stall), 32'd0);
        checkOutput("midrst_cnt", 32'(bus.stall_cnt), 32'd0);
        checkOutput("midrst_fwd_rsD", 32'(bus.fwd_rsD), 32'd0);
        tick();
        nops(3);

        // Self-dependent writer repeats: two stalls per issue, enough to saturate the counter.
        for (int i = 0; i < 400; i++) step(0, 3, 3, 1, 0, 1, 1'b1);
        applyStimulus(3, 3, 0, 0, 0, 0, 1'b1);
        checkOutput("cnt_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
        tick();

        // Random tuples over a small register set so hits are frequent.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 49) != 0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
